// File: rtl/ov7670_pkg.sv
// ov7670_pkg: capture state encoding, video geometry and RGB565 field layout shared by capture and display
package ov7670_pkg;

    typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE} cap_state_t;

    localparam int QVGA_W = 320;
    localparam int QVGA_H = 240;
    localparam int VGA_W  = 640;
    localparam int VGA_H  = 480;

    localparam int RGB_R_MSB = 15;
    localparam int RGB_R_LSB = 11;
    localparam int RGB_G_MSB = 10;
    localparam int RGB_G_LSB = 5;
    localparam int RGB_B_MSB = 4;
    localparam int RGB_B_LSB = 0;

    function automatic logic [15:0] rgb565(input logic [4:0] r, input logic [5:0] g, input logic [4:0] b);
        return {r, g, b};
    endfunction

endpackage

// File: rtl/ov7670_capture_byte_pair.sv
// cam_byte_pair: joins two camera bytes into one RGB565 word and issues the registered write strobe
module cam_byte_pair
    import ov7670_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_take,
    input  logic        i_drop,
    input  logic        i_block,
    input  logic [7:0]  i_d,
    output logic        o_phase,
    output logic [15:0] o_data,
    output logic        o_wr
);

    logic       r_phase;
    logic [7:0] r_hi;
    logic [15:0] r_data;
    logic       r_wr;

    // first byte is held, second byte completes the word unless the frame buffer is full
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= 1'b0;
            r_hi    <= '0;
            r_data  <= '0;
            r_wr    <= 1'b0;
        end else begin
            r_wr <= 1'b0;
            if (i_clear || i_drop) begin
                r_phase <= 1'b0;
            end else if (i_take) begin
                r_phase <= ~r_phase;
                if (!r_phase) begin
                    r_hi <= i_d;
                end else if (!i_block) begin
                    r_data <= {r_hi, i_d};
                    r_wr   <= 1'b1;
                end
            end
        end
    end

    assign o_phase = r_phase;
    assign o_data  = r_data;
    assign o_wr    = r_wr;

endmodule

// File: rtl/ov7670_capture.sv
// ov7670_capture: frame-synchronised OV7670 byte capture into sequential RGB565 frame-buffer writes
module ov7670_capture
    import ov7670_pkg::*;
#(
    parameter int FRAME_PIXELS = QVGA_W * QVGA_H,
    parameter int ADDR_WIDTH   = 17,
    parameter int LINE_WIDTH   = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  capture_en,
    input  logic                  vsync,
    input  logic                  href,
    input  logic [7:0]            d,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [15:0]           wr_data,
    output logic                  wr_en,
    output logic [LINE_WIDTH-1:0] line_count,
    output logic                  frame_done,
    output logic                  overflow,
    output logic                  odd_line
);

    cap_state_t            r_state;
    logic                  r_vsync_q;
    logic                  r_href_q;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [LINE_WIDTH-1:0] r_line_count;
    logic                  r_frame_done;
    logic                  r_overflow;
    logic                  r_odd_line;

    logic w_vs_fall, w_vs_rise, w_hr_fall, w_active, w_start;
    logic w_take, w_drop, w_clear, w_block, w_phase, w_wr;

    assign w_vs_fall = r_vsync_q & ~vsync;
    assign w_vs_rise = ~r_vsync_q & vsync;
    assign w_hr_fall = r_href_q & ~href;
    assign w_active  = r_state == ACTIVE;
    assign w_start   = (r_state == WAIT_VS) & w_vs_fall;
    assign w_take    = w_active & href & ~w_vs_rise;
    assign w_drop    = w_active & w_hr_fall;
    assign w_clear   = w_start | (w_active & w_vs_rise);
    assign w_block   = r_wr_addr == ADDR_WIDTH'(FRAME_PIXELS);

    cam_byte_pair u_pair (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .i_take  (w_take),
        .i_drop  (w_drop),
        .i_block (w_block),
        .i_d     (d),
        .o_phase (w_phase),
        .o_data  (wr_data),
        .o_wr    (w_wr)
    );

    // frame state machine, address/line counters and sticky status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_vsync_q    <= 1'b0;
            r_href_q     <= 1'b0;
            r_wr_addr    <= '0;
            r_line_count <= '0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
            r_odd_line   <= 1'b0;
        end else begin
            r_vsync_q    <= vsync;
            r_href_q     <= href;
            r_frame_done <= 1'b0;
            if (w_wr)
                r_wr_addr <= r_wr_addr + 1'b1;
            case (r_state)
                IDLE: begin
                    if (capture_en)
                        r_state <= WAIT_VS;
                end
                WAIT_VS: begin
                    if (w_vs_fall) begin
                        r_state      <= ACTIVE;
                        r_wr_addr    <= '0;
                        r_line_count <= '0;
                        r_overflow   <= 1'b0;
                        r_odd_line   <= 1'b0;
                    end else if (!capture_en) begin
                        r_state <= IDLE;
                    end
                end
                ACTIVE: begin
                    if (w_hr_fall) begin
                        if (~&r_line_count)
                            r_line_count <= r_line_count + 1'b1;
                        if (w_phase)
                            r_odd_line <= 1'b1;
                    end
                    if (w_take && w_phase && w_block)
                        r_overflow <= 1'b1;
                    if (w_vs_rise) begin
                        r_frame_done <= 1'b1;
                        r_state      <= capture_en ? WAIT_VS : IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign wr_addr    = r_wr_addr;
    assign wr_en      = w_wr;
    assign line_count = r_line_count;
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;
    assign odd_line   = r_odd_line;

endmodule

// File: tb/tb_ov7670_capture.sv
// tb_ov7670_capture: randomized frames checked against a per-frame pixel list model
module tb_ov7670_capture;

    localparam int FP = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        capture_en = 1'b0;
    logic        vsync = 1'b0;
    logic        href = 1'b0;
    logic [7:0]  d = '0;
    logic [16:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_en;
    logic [9:0]  line_count;
    logic        frame_done;
    logic        overflow;
    logic        odd_line;

    int total = 0;
    int bad = 0;
    int fd_cnt = 0;
    int lens[4];
    logic [32:0] cap_q[$];
    logic [32:0] exp_q[$];
    logic [7:0]  pat[4] = '{8'hF8, 8'h00, 8'h07, 8'hE0};

    always #5 clk = ~clk;

    ov7670_capture #(.FRAME_PIXELS(FP), .ADDR_WIDTH(17), .LINE_WIDTH(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .capture_en (capture_en),
        .vsync      (vsync),
        .href       (href),
        .d          (d),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .line_count (line_count),
        .frame_done (frame_done),
        .overflow   (overflow),
        .odd_line   (odd_line)
    );

    always @(negedge clk) begin
        if (wr_en)
            cap_q.push_back({wr_addr, wr_data});
        if (frame_done)
            fd_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_lines"}, line_count, 0);
        chk({tag, "_fdone"}, frame_done, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_odd"}, odd_line, 0);
    endtask

    // model: a frame is captured iff capture_en is high at VSYNC fall; pixels are byte pairs within a line
    task automatic run_frame(input int nlines, input bit fixed, input bit drop_en);
        int base, fd0, npix;
        bit odd, cap;
        logic [7:0] hi;
        exp_q.delete();
        vsync = 1'b1;
        step(3);
        cap = capture_en;
        vsync = 1'b0;
        step(2);
        base = cap_q.size();
        fd0 = fd_cnt;
        npix = 0;
        odd = 1'b0;
        hi = '0;
        for (int l = 0; l < nlines; l++) begin
            for (int b = 0; b < lens[l]; b++) begin
                href = 1'b1;
                d = fixed ? pat[b % 4] : 8'($urandom);
                if (b % 2 == 0) begin
                    hi = d;
                end else begin
                    if (npix < FP)
                        exp_q.push_back({17'(npix), hi, d});
                    npix++;
                end
                if (drop_en && l == nlines - 1 && b == 0)
                    capture_en = 1'b0;
                step();
            end
            if (lens[l] % 2 == 1)
                odd = 1'b1;
            href = 1'b0;
            step(2 + $urandom_range(0, 2));
        end
        if (!cap) begin
            exp_q.delete();
        end
        vsync = 1'b1;
        step();
        chk("frame_done", frame_done, 32'(cap));
        step();
        chk("frame_done_once", fd_cnt - fd0, 32'(cap));
        chk("nwrites", cap_q.size() - base, exp_q.size());
        foreach (exp_q[i]) begin
            if (base + i < cap_q.size()) begin
                chk("waddr", cap_q[base + i][32:16], exp_q[i][32:16]);
                chk("wdata", cap_q[base + i][15:0], exp_q[i][15:0]);
            end
        end
        if (cap) begin
            chk("line_count", line_count, nlines);
            chk("overflow", overflow, 32'(npix > FP));
            chk("odd_line", odd_line, 32'(odd));
        end
    endtask

    initial begin
        int base;
        step(3);
        chk_reset_state("rst");
        rst = 1'b0;
        capture_en = 1'b1;
        step(2);

        lens = '{8, 8, 0, 0};
        run_frame(2, 1'b1, 1'b0);

        for (int f = 0; f < 4; f++) begin
            for (int l = 0; l < 4; l++)
                lens[l] = 2 * $urandom_range(1, 3);
            run_frame($urandom_range(1, 3), 1'b0, 1'b0);
        end

        lens = '{8, 8, 4, 0};
        run_frame(3, 1'b0, 1'b0);
        lens = '{6, 4, 0, 0};
        run_frame(2, 1'b0, 1'b0);

        lens = '{7, 8, 0, 0};
        run_frame(2, 1'b1, 1'b0);

        lens = '{4, 4, 0, 0};
        run_frame(2, 1'b0, 1'b1);
        run_frame(2, 1'b0, 1'b0);
        capture_en = 1'b1;
        run_frame(2, 1'b0, 1'b0);

        vsync = 1'b1;
        step(3);
        vsync = 1'b0;
        step(2);
        base = cap_q.size();
        href = 1'b1;
        for (int b = 0; b < 5; b++) begin
            d = 8'($urandom);
            step();
        end
        d = 8'h55;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_state("midrst");
        chk("pre_rst_writes", cap_q.size() - base, 2);
        base = cap_q.size();
        for (int b = 0; b < 4; b++) begin
            d = 8'($urandom);
            step();
        end
        href = 1'b0;
        step(3);
        vsync = 1'b1;
        step(2);
        chk("post_rst_writes", cap_q.size() - base, 0);
        chk("post_rst_fdone", frame_done, 0);
        lens = '{4, 6, 0, 0};
        run_frame(2, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
